// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: run/halt state
// encoding, the bubble instruction and the default reset PC.
package if_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IM_AW   = 12;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register.
//   load   : capture instr_d / pc4_d and mark valid
//   bubble : capture NOP, clear valid, keep pc4 (takes priority over load)
//   neither: hold
// Outputs instr, pc4, valid are registered.
module ifid_reg
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc4_d,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc4,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, RUN/HALTED control, fetch-fault
// tracking and valid-instruction counter, feeding an IF/ID register.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   stall                            hold PC and IF/ID
//   redirect_valid, redirect_target  load a new (word-aligned) PC
//   halt, go                         enter / leave HALTED
//   im_addr / im_data                external instruction memory
//   pc                               current fetch PC
//   ifid_instr, ifid_pc4, ifid_valid IF/ID register contents
//   fetch_fault                      sticky misaligned/out-of-range flag
//   instr_count                      valid instructions captured
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IM_BYTES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             halt,
  input  logic             go,
  output logic [IM_AW-1:0] im_addr,
  input  logic [XLEN-1:0]  im_data,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  ifid_instr,
  output logic [XLEN-1:0]  ifid_pc4,
  output logic             ifid_valid,
  output logic             fetch_fault,
  output logic [XLEN-1:0]  instr_count
);

  localparam logic [XLEN-1:0] IM_LIMIT = XLEN'(IM_BYTES);

  fetch_state_t    state;
  logic            do_halt, do_go, do_advance, fetch_ok;
  logic            pc_bad, tgt_bad, ifid_bubble;
  logic [XLEN-1:0] pc_plus4, tgt_aligned;

  assign im_addr = pc[IM_AW-1:0];

  // Per-edge decode; redirect outranks halt, which outranks stall.
  always_comb begin
    do_halt     = 1'b0;
    do_go       = 1'b0;
    do_advance  = 1'b0;
    pc_plus4    = pc + 32'd4;
    tgt_aligned = {redirect_target[XLEN-1:2], 2'b00};
    tgt_bad     = (redirect_target[1:0] != 2'b00) || (tgt_aligned >= IM_LIMIT);
    pc_bad      = (pc[1:0] != 2'b00) || (pc >= IM_LIMIT);
    if (!redirect_valid) begin
      if (state == ST_RUN) begin
        do_halt    = halt;
        do_advance = !halt && !stall;
      end else begin
        do_go = go && !halt;
      end
    end
    // Once a fault is latched every fetch becomes a bubble until cleared.
    fetch_ok    = do_advance && !fetch_fault && !pc_bad;
    ifid_bubble = redirect_valid || do_halt || (state == ST_HALTED) ||
                  (do_advance && !fetch_ok);
  end

  // PC, state, fault flag and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= ST_RUN;
      fetch_fault <= 1'b0;
      instr_count <= '0;
    end else if (redirect_valid) begin
      pc          <= tgt_aligned;
      fetch_fault <= tgt_bad;
    end else begin
      if (do_halt) begin
        state <= ST_HALTED;
      end else if (do_go) begin
        state <= ST_RUN;
      end
      if (do_advance) begin
        pc <= pc_plus4;
        if (pc_bad) begin
          fetch_fault <= 1'b1;
        end
      end
      if (fetch_ok) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (fetch_ok),
    .bubble  (ifid_bubble),
    .instr_d (im_data),
    .pc4_d   (pc_plus4),
    .instr   (ifid_instr),
    .pc4     (ifid_pc4),
    .valid   (ifid_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, halt, go;
  logic [31:0] redirect_target;
  logic [11:0] im_addr;
  logic [31:0] im_data, pc, ifid_instr, ifid_pc4, instr_count;
  logic        ifid_valid, fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  bit          m_valid, m_fault, m_halted;

  typedef struct {
    logic        st, rv;
    logic [31:0] tgt;
    logic        h, g;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    logic [31:0] e_count;
    logic        e_fault;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  // Instruction memory holds its own word index.
  assign im_data = 32'(im_addr >> 2);

  if_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .go              (go),
    .im_addr         (im_addr),
    .im_data         (im_data),
    .pc              (pc),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid),
    .fetch_fault     (fetch_fault),
    .instr_count     (instr_count)
  );

  function automatic vec_t mk(input logic st, rv, input logic [31:0] tgt,
                              input logic h, g, input logic [31:0] p, ins, p4,
                              input logic v, input logic [31:0] c, input logic f);
    vec_t r;
    r.st = st; r.rv = rv; r.tgt = tgt; r.h = h; r.g = g;
    r.e_pc = p; r.e_instr = ins; r.e_pc4 = p4; r.e_valid = v;
    r.e_count = c; r.e_fault = f;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input logic [31:0] p, ins, p4,
                           input logic v, input logic [31:0] c, input logic f);
    check({tag, " pc"},          pc,                 p);
    check({tag, " im_addr"},     32'(im_addr),       32'(p[11:0]));
    check({tag, " ifid_instr"},  ifid_instr,         ins);
    check({tag, " ifid_pc4"},    ifid_pc4,           p4);
    check({tag, " ifid_valid"},  32'(ifid_valid),    32'(v));
    check({tag, " instr_count"}, instr_count,        c);
    check({tag, " fetch_fault"}, 32'(fetch_fault),   32'(f));
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_count = 0;
    m_valid = 0; m_fault = 0; m_halted = 0;
  endtask

  // One rising edge of the reference, rules applied in priority order.
  task automatic model_edge();
    if (redirect_valid) begin
      m_pc    = redirect_target & ~32'd3;
      m_fault = (redirect_target % 4 != 0) || (m_pc >= 32'd4096);
      m_instr = 0; m_valid = 0;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
      if (go && !halt) m_halted = 0;
    end else if (halt) begin
      m_halted = 1; m_instr = 0; m_valid = 0;
    end else if (!stall) begin
      if (m_fault || m_pc >= 32'd4096) begin
        m_fault = 1; m_instr = 0; m_valid = 0;
      end else begin
        m_instr = m_pc / 4;
        m_pc4   = m_pc + 4;
        m_valid = 1;
        m_count = m_count + 1;
      end
      m_pc = m_pc + 4;
    end
  endtask

  // Drive at negedge, let one rising edge pass, return at next negedge.
  task automatic step(input logic st, rv, input logic [31:0] tgt, input logic h, g);
    stall = st; redirect_valid = rv; redirect_target = tgt; halt = h; go = g;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; redirect_valid = 0; redirect_target = 0; halt = 0; go = 0;
    model_reset();

    // Directed sequence with hand-derived expectations.
    tbl.push_back(mk(0,0,0,0,0, 32'h4,    0,      32'h4,    1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h8,    1,      32'h8,    1, 2, 0));
    tbl.push_back(mk(1,0,0,0,0, 32'h8,    1,      32'h8,    1, 2, 0));
    tbl.push_back(mk(1,0,0,0,0, 32'h8,    1,      32'h8,    1, 2, 0));
    tbl.push_back(mk(1,0,0,0,0, 32'h8,    1,      32'h8,    1, 2, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'hC,    2,      32'hC,    1, 3, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h10,   3,      32'h10,   1, 4, 0));
    tbl.push_back(mk(0,1,32'h8,0,0, 32'h8, 0,     32'h10,   0, 4, 0));
    tbl.push_back(mk(1,1,32'h40,0,0, 32'h40, 0,   32'h10,   0, 4, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h44,   32'h10, 32'h44,   1, 5, 0));
    tbl.push_back(mk(0,1,32'h10,0,0, 32'h10, 0,   32'h44,   0, 5, 0));
    tbl.push_back(mk(0,0,0,1,0, 32'h10,   0,      32'h44,   0, 5, 0));
    tbl.push_back(mk(0,0,0,1,1, 32'h10,   0,      32'h44,   0, 5, 0));
    tbl.push_back(mk(1,0,0,0,0, 32'h10,   0,      32'h44,   0, 5, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h10,   0,      32'h44,   0, 5, 0));
    tbl.push_back(mk(1,0,0,0,0, 32'h10,   0,      32'h44,   0, 5, 0));
    tbl.push_back(mk(0,0,0,0,1, 32'h10,   0,      32'h44,   0, 5, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h14,   4,      32'h14,   1, 6, 0));
    tbl.push_back(mk(0,1,32'h1002,0,0, 32'h1000, 0, 32'h14, 0, 6, 1));
    tbl.push_back(mk(0,0,0,0,0, 32'h1004, 0,      32'h14,   0, 6, 1));
    tbl.push_back(mk(0,0,0,0,0, 32'h1008, 0,      32'h14,   0, 6, 1));
    tbl.push_back(mk(0,1,32'h20,0,0, 32'h20, 0,   32'h14,   0, 6, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h24,   8,      32'h24,   1, 7, 0));
    tbl.push_back(mk(0,0,0,1,0, 32'h24,   0,      32'h24,   0, 7, 0));
    tbl.push_back(mk(0,1,32'h30,0,0, 32'h30, 0,   32'h24,   0, 7, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h30,   0,      32'h24,   0, 7, 0));
    tbl.push_back(mk(0,0,0,0,1, 32'h30,   0,      32'h24,   0, 7, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h34,   32'hC,  32'h34,   1, 8, 0));
    tbl.push_back(mk(0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 0, 32'h34, 0, 8, 1));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,    0,      32'h34,   0, 8, 1));
    tbl.push_back(mk(0,1,32'h0,0,0, 32'h0, 0,     32'h34,   0, 8, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h4,    0,      32'h4,    1, 9, 0));
    tbl.push_back(mk(0,1,32'hFF8,0,0, 32'hFF8, 0, 32'h4,    0, 9, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'hFFC,  32'h3FE, 32'hFFC, 1, 10, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h1000, 32'h3FF, 32'h1000, 1, 11, 0));
    tbl.push_back(mk(0,0,0,0,0, 32'h1004, 0,      32'h1000, 0, 11, 1));
    tbl.push_back(mk(0,1,32'h0,0,0, 32'h0, 0,     32'h1000, 0, 11, 0));

    repeat (2) @(negedge clk);
    check_all("reset", 32'h0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].rv, tbl[i].tgt, tbl[i].h, tbl[i].g);
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pc4,
                tbl[i].e_valid, tbl[i].e_count, tbl[i].e_fault);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] t;
      if ($urandom_range(0, 3) == 0) t = $urandom();
      else t = 32'($urandom_range(0, 1023)) << 2;
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, t,
           $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
      check_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pc4, m_valid, m_count, m_fault);
    end

    // Async reset while halted with a redirect pending.
    step(0, 1, 32'h100, 0, 0);
    step(0, 0, 0, 1, 0);
    check("halted pc", pc, 32'h100);
    stall = 1; redirect_valid = 1; redirect_target = 32'h200;
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_all("rst_held", 32'h0, 0, 0, 0, 0, 0);
    model_reset();
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    check_all("post_rst", 32'h4, 0, 32'h4, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    check_all("post_rst2", 32'h8, 1, 32'h8, 1, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IM_BYTES, default 4096, size of instruction memory in bytes; a PC at or above it is a fetch fault.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  hold PC and IF/ID register (hazard from decode).
REQ-006 redirect_valid  input  1  branch/jump taken; load redirect_target.
REQ-007 redirect_target  input  32  new PC for a redirect.
REQ-008 halt  input  1  one-cycle pulse; enter HALTED (syscall stop).
REQ-009 go  input  1  one-cycle pulse; leave HALTED.
REQ-010 im_addr  output  12  byte address to instruction memory, equals pc[11:0].
REQ-011 im_data  input  32  instruction word returned combinationally for im_addr.
REQ-012 pc  output  32  current fetch PC.
REQ-013 ifid_instr  output  32  registered instruction for decode.
REQ-014 ifid_pc4  output  32  registered PC+4 of ifid_instr.
REQ-015 ifid_valid  output  1  ifid_instr is a real instruction, not a bubble.
REQ-016 fetch_fault  output  1  registered; PC misaligned or at/above IM_BYTES.
REQ-017 instr_count  output  32  number of valid instructions captured into IF/ID.

Function
REQ-018 States: RUN and HALTED, 1-bit state register.
REQ-019 Per-edge priority: redirect > halt > stall > normal advance.
REQ-020 RUN, no stall/redirect: pc <= pc+4 (mod 2^32); ifid_instr <= im_data; ifid_pc4 <= pc+4; ifid_valid <= 1; instr_count += 1.
REQ-021 Fetch latency: the instruction at address A appears on ifid_instr on the edge after pc == A.
REQ-022 stall=1 with no redirect: pc, ifid_instr, ifid_pc4, ifid_valid and instr_count hold.
REQ-023 redirect_valid=1, any state, stall ignored: pc <= {redirect_target[31:2],2'b00}; ifid_instr <= 0; ifid_valid <= 0; ifid_pc4 holds; instr_count holds.
REQ-024 redirect_target[1:0] != 0 sets fetch_fault for the next cycle; the low bits are still forced to zero.
REQ-025 halt=1 in RUN with no redirect: state <= HALTED; pc holds; IF/ID loads a bubble.
REQ-026 HALTED: pc holds, ifid_valid=0, ifid_instr=0, instr_count holds, stall has no effect.
REQ-027 go=1 in HALTED with halt=0: state <= RUN; normal fetch resumes on the following edge.
REQ-028 halt and go in the same cycle: halt wins and the state is HALTED.
REQ-029 Redirect in HALTED: pc is updated and the state stays HALTED.
REQ-030 fetch_fault <= 1 when the PC being fetched is >= IM_BYTES.
REQ-031 A faulting fetch captures a bubble instead of im_data.
REQ-032 fetch_fault is sticky until reset or a redirect to a legal target.
REQ-033 pc+4 wraps from 32'hFFFF_FFFC to 0 without error, other than the fault rule.
REQ-034 instr_count wraps modulo 2^32.

Reset
REQ-035 rst_n low asynchronously forces: pc=RESET_PC; state=RUN; ifid_instr=0; ifid_pc4=0; ifid_valid=0; fetch_fault=0; instr_count=0.
REQ-036 Reset asserted mid-stall, mid-halt or mid-redirect discards the pending operation; the first fetch after release is from RESET_PC.

Structure
REQ-037 The shared package holds the RUN/HALTED state encoding, the NOP/bubble constant 32'h0000_0000 and the default reset PC.
REQ-038 One sub-module, ifid_reg, holds the IF/ID pipeline register with load, hold and bubble controls.
REQ-039 The PC register, state machine and counter live in if_stage.
REQ-040 The instruction memory is external and connected through im_addr/im_data only.

Verification
REQ-041 Reset release, 4 free-running cycles, im_data=word index -> pc 0,4,8,12,16; ifid_pc4 4,8,12,16; instr_count=4.
REQ-042 pc=8, stall high 3 cycles -> pc stays 8; ifid_instr/ifid_valid unchanged; instr_count unchanged.
REQ-043 pc=8 with stall=1 and redirect_valid=1, target 32'h40 -> next pc=0x40, ifid_valid=0, then 0x44 with valid=1.
REQ-044 halt pulse at pc=0x10, go 5 cycles later -> pc holds 0x10, 5 bubbles, fetch resumes at 0x10, instr_count paused.
REQ-045 Redirect to 32'h1002 -> pc=0x1000, fetch_fault=1, bubbles until redirect to 0x20 clears fault.
REQ-046 rst_n low during HALTED with a redirect pending -> all outputs at reset values at once; first fetch from RESET_PC.
